// File: rtl/first_zero_len_pipe_if.sv
// Beat-in / result-out bundle for first_zero_len_pipe.
// The slave modport is the reducer; master is the byte-compare side plus the match selector.
interface first_zero_len_pipe_if #(
    parameter int VEC   = 16,
    parameter int IDX_W = $clog2(VEC) + 1,
    parameter int LEN_W = 9
);
    logic             in_valid;
    logic [VEC-1:0]   in_match;
    logic             in_first;
    logic             in_last;
    logic             beat_valid;
    logic [IDX_W-1:0] beat_min_i;
    logic             len_valid;
    logic [LEN_W-1:0] len_out;
    logic             seq_err;
    logic [31:0]      dbg_done_cnt;

    modport master (
        output in_valid, in_match, in_first, in_last,
        input  beat_valid, beat_min_i, len_valid, len_out, seq_err, dbg_done_cnt
    );

    modport slave (
        input  in_valid, in_match, in_first, in_last,
        output beat_valid, beat_min_i, len_valid, len_out, seq_err, dbg_done_cnt
    );
endinterface

// File: rtl/first_zero_len_pipe.sv
// Pipelined first-zero lane reducer with Deflate match-length accumulation (cap MAX_LEN).
// Optional completed-candidate counter on dbg_done_cnt, enabled by defining FZL_DONE_CNT_EN.

module fzl_node #(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] a,
    input  logic [IDX_W-1:0] b,
    output logic [IDX_W-1:0] y
);
    // a always covers the lower lanes and "no zero" is the largest code, so min picks the winner
    assign y = (a <= b) ? a : b;
endmodule

module first_zero_len_pipe #(
    parameter int VEC     = 16,
    parameter int LOG2V   = $clog2(VEC),
    parameter int IDX_W   = LOG2V + 1,
    parameter int MAX_LEN = 258,
    parameter int LEN_W   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    first_zero_len_pipe_if.slave bus
);
    localparam logic [IDX_W-1:0] NONE = IDX_W'(VEC);
    localparam logic [LEN_W-1:0] CAP  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, RUN, SKIP} state_t;

    logic [LOG2V:0]            vld_pipe, fst_pipe, lst_pipe;
    logic [VEC-1:0]            match_q;
    logic [VEC-1:0][IDX_W-1:0] leaf;
    // Heap layout: node j has children 2j (lower lanes) and 2j+1; indices >= VEC are leaves.
    logic [VEC-1:1][IDX_W-1:0] heap_q, heap_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            fst_pipe <= '0;
            lst_pipe <= '0;
            match_q  <= '0;
            heap_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LOG2V-1:0], bus.in_valid};
            fst_pipe <= {fst_pipe[LOG2V-1:0], bus.in_first};
            lst_pipe <= {lst_pipe[LOG2V-1:0], bus.in_last};
            match_q  <= bus.in_match;
            heap_q   <= heap_d;
        end
    end

    for (genvar i = 0; i < VEC; i++) begin : g_leaf
        assign leaf[i] = match_q[i] ? NONE : IDX_W'(i);
    end

    for (genvar j = 1; j < VEC; j++) begin : g_node
        logic [IDX_W-1:0] lo, hi;
        if (2 * j >= VEC) begin : g_from_leaf
            assign lo = leaf[2*j-VEC];
            assign hi = leaf[2*j+1-VEC];
        end else begin : g_from_node
            assign lo = heap_q[2*j];
            assign hi = heap_q[2*j+1];
        end
        fzl_node #(.IDX_W(IDX_W)) u_node (.a(lo), .b(hi), .y(heap_d[j]));
    end

    logic             b_valid, b_first, b_last;
    logic [IDX_W-1:0] m;

    assign b_valid = vld_pipe[LOG2V];
    assign b_first = fst_pipe[LOG2V];
    assign b_last  = lst_pipe[LOG2V];
    assign m       = heap_q[1];

    state_t           state, state_n;
    logic [LEN_W-1:0] acc, acc_n, base, sum, len_q, len_n;
    logic             fire, err_set, len_vld_q, err_q;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        len_n   = len_q;
        fire    = 1'b0;
        err_set = 1'b0;
        base    = b_first ? '0 : acc;
        sum     = base + LEN_W'(m);
        if (b_valid) begin
            if (!b_first && state == IDLE) begin
                err_set = 1'b1;
            end else if (b_first || state == RUN) begin
                if (m != NONE || b_last) begin
                    fire    = 1'b1;
                    len_n   = (sum > CAP) ? CAP : sum;
                    acc_n   = '0;
                    state_n = b_last ? IDLE : SKIP;
                end else if (sum >= CAP) begin
                    fire    = 1'b1;
                    len_n   = CAP;
                    acc_n   = '0;
                    state_n = SKIP;
                end else begin
                    acc_n   = sum;
                    state_n = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            len_vld_q <= 1'b0;
            len_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            len_vld_q <= fire;
            len_q     <= len_n;
            err_q     <= err_q | err_set;
        end
    end

`ifdef FZL_DONE_CNT_EN
    logic [31:0] done_cnt;
    // Counts on the same edge that raises len_valid, so both move together
    always_ff @(posedge clk) begin
        if (!rst_n)    done_cnt <= '0;
        else if (fire) done_cnt <= done_cnt + 32'd1;
    end
    assign bus.dbg_done_cnt = done_cnt;
`else
    assign bus.dbg_done_cnt = '0;
`endif

    assign bus.beat_valid = b_valid;
    assign bus.beat_min_i = m;
    assign bus.len_valid  = len_vld_q;
    assign bus.len_out    = len_q;
    assign bus.seq_err    = err_q;
endmodule
